// File: rtl/booth_mul_seq.sv
// Radix-2 Booth sequential signed multiplier: one Booth step per clock,
// WIDTH iterations per product, with a one-cycle done pulse when P updates.
module booth_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH:0]  acc;
    logic [WIDTH:0]  m;
    logic [WIDTH-1:0] q;
    logic            q_m1;
    logic [CW-1:0]   count;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   addsub;
    logic [WIDTH:0]   acc_sel;
    logic [WIDTH:0]   acc_nx;
    logic [WIDTH-1:0] q_nx;

    // WIDTH+1-bit arithmetic with carry dropped keeps A = -2^(WIDTH-1) exact.
    assign sum     = acc + m;
    assign diff    = acc - m;
    assign addsub  = q[0] ? diff : sum;
    assign acc_sel = (q[0] ^ q_m1) ? addsub : acc;

    // Arithmetic right shift of {acc_sel, q, q_m1}.
    assign acc_nx  = {acc_sel[WIDTH], acc_sel[WIDTH:1]};
    assign q_nx    = {acc_sel[0], q[WIDTH-1:1]};

    // NOTE: state registers use non-blocking assignments so every register
    // sees the pre-edge values of the others, exactly like the flops do.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            m     <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            count <= '0;
            P     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m     <= {A[WIDTH-1], A};
                        acc   <= '0;
                        q     <= B;
                        q_m1  <= 1'b0;
                        count <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_nx;
                    q     <= q_nx;
                    q_m1  <= q[0];
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        P     <= {acc_nx[WIDTH-1:0], q_nx};
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
